// File: rtl/apb_uart_fifo_bridge.sv
// APB3 slave bridging the system bus to a UART core through TX/RX FIFOs,
// with occupancy status, sticky RX overrun, interrupt and wait-state timeout.
module apb_uart_fifo_bridge #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CHAR_WIDTH = 8,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned BAUD_WIDTH = 20,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   input  logic                  PSEL,
   input  logic                  PENABLE,
   input  logic                  PWRITE,
   input  logic [3:0]            PADDR,
   input  logic [DATA_WIDTH-1:0] PWDATA,
   output logic [DATA_WIDTH-1:0] PRDATA,
   output logic                  PREADY,
   output logic                  PSLVERR,
   output logic [CHAR_WIDTH-1:0] tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   input  logic [CHAR_WIDTH-1:0] rx_data,
   input  logic                  rx_valid,
   output logic [BAUD_WIDTH-1:0] baud_div,
   output logic                  irq
);

   localparam int unsigned AW    = $clog2(FIFO_DEPTH);
   localparam int unsigned PW    = AW + 1;
   localparam int unsigned WW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic        TO_EN = (TIMEOUT != 0);

   logic [CHAR_WIDTH-1:0] r_tx_mem [FIFO_DEPTH];
   logic [CHAR_WIDTH-1:0] r_rx_mem [FIFO_DEPTH];
   logic [PW-1:0]         r_tx_wr, r_tx_rd, r_rx_wr, r_rx_rd;
   logic [WW-1:0]         r_wait;
   logic [3:0]            r_cntrl;
   logic [BAUD_WIDTH-1:0] r_baud;
   logic                  r_ovr;

   logic       w_access, w_sel_data, w_sel_stat, w_sel_ctrl, w_stall, w_timeout, w_done;
   logic       w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
   logic       w_tx_push, w_tx_pop, w_rx_push, w_rx_pop, w_rx_req, w_ovr_set, w_ovr_clr;
   logic [PW-1:0] w_tx_count, w_rx_count;
   logic [23:0]   w_status;
   logic          w_unused;

   // FIFO flags and occupancy from the extended-pointer pairs
   assign w_tx_empty = (r_tx_wr == r_tx_rd);
   assign w_rx_empty = (r_rx_wr == r_rx_rd);
   assign w_tx_full  = (r_tx_wr[AW-1:0] == r_tx_rd[AW-1:0]) && (r_tx_wr[AW] != r_tx_rd[AW]);
   assign w_rx_full  = (r_rx_wr[AW-1:0] == r_rx_rd[AW-1:0]) && (r_rx_wr[AW] != r_rx_rd[AW]);
   assign w_tx_count = r_tx_wr - r_tx_rd;
   assign w_rx_count = r_rx_wr - r_rx_rd;

   // APB access decode; only DATA accesses can stall
   assign w_access   = PSEL & PENABLE;
   assign w_sel_data = (PADDR[3:2] == 2'd0);
   assign w_sel_stat = (PADDR[3:2] == 2'd1);
   assign w_sel_ctrl = (PADDR[3:2] == 2'd2);
   assign w_stall    = w_access & w_sel_data & (PWRITE ? w_tx_full : w_rx_empty);
   assign w_timeout  = w_stall & TO_EN & (r_wait == WW'(TIMEOUT));
   assign PREADY     = ~w_access | ~w_stall | w_timeout;
   assign PSLVERR    = w_timeout;
   assign w_done     = w_access & PREADY & ~w_timeout;

   // FIFO handshakes and overrun detection
   assign tx_valid  = r_cntrl[0] & ~w_tx_empty;
   assign tx_data   = r_tx_mem[r_tx_rd[AW-1:0]];
   assign w_tx_pop  = tx_valid & tx_ready;
   assign w_tx_push = w_done & PWRITE & w_sel_data;
   assign w_rx_pop  = w_done & ~PWRITE & w_sel_data;
   assign w_rx_req  = rx_valid & r_cntrl[1];
   assign w_rx_push = w_rx_req & (~w_rx_full | w_rx_pop);
   assign w_ovr_set = w_rx_req & w_rx_full & ~w_rx_pop;
   assign w_ovr_clr = w_done & PWRITE & w_sel_stat & PWDATA[4];

   assign baud_div = r_baud;
   assign irq      = (r_cntrl[2] & ~w_rx_empty) | (r_cntrl[3] & w_tx_empty) | (r_ovr & r_cntrl[2]);
   assign w_status = {8'(w_rx_count), 8'(w_tx_count), 3'b000, r_ovr,
                      w_rx_empty, w_rx_full, w_tx_empty, w_tx_full};
   assign w_unused = ^{PADDR[1:0], PWDATA};

   // Read mux: zero outside a read access and on timeout
   always_comb begin
      PRDATA = '0;
      if (w_access && !PWRITE && !w_timeout) begin
         case (PADDR[3:2])
            2'd0:    PRDATA = DATA_WIDTH'(r_rx_mem[r_rx_rd[AW-1:0]]);
            2'd1:    PRDATA = DATA_WIDTH'(w_status);
            2'd2:    PRDATA = DATA_WIDTH'(r_cntrl);
            default: PRDATA = DATA_WIDTH'(r_baud);
         endcase
      end
   end

   // FIFO storage, intentionally not reset
   always_ff @(posedge PCLK) begin
      if (w_tx_push) r_tx_mem[r_tx_wr[AW-1:0]] <= PWDATA[CHAR_WIDTH-1:0];
      if (w_rx_push) r_rx_mem[r_rx_wr[AW-1:0]] <= rx_data;
   end

   // FIFO pointers
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_tx_wr <= '0;
         r_tx_rd <= '0;
         r_rx_wr <= '0;
         r_rx_rd <= '0;
      end else begin
         if (w_tx_push) r_tx_wr <= r_tx_wr + PW'(1);
         if (w_tx_pop)  r_tx_rd <= r_tx_rd + PW'(1);
         if (w_rx_push) r_rx_wr <= r_rx_wr + PW'(1);
         if (w_rx_pop)  r_rx_rd <= r_rx_rd + PW'(1);
      end
   end

   // Wait-state counter for stalled DATA accesses
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn)                r_wait <= '0;
      else if (!PSEL)              r_wait <= '0;
      else if (w_access && PREADY) r_wait <= '0;
      else if (w_access)           r_wait <= r_wait + WW'(1);
   end

   // Control/baud registers and sticky overrun (set beats clear)
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_cntrl <= '0;
         r_baud  <= '0;
         r_ovr   <= 1'b0;
      end else begin
         if (w_done && PWRITE && w_sel_ctrl) r_cntrl <= PWDATA[3:0];
         if (w_done && PWRITE && (PADDR[3:2] == 2'd3)) r_baud <= PWDATA[BAUD_WIDTH-1:0];
         if (w_ovr_set)      r_ovr <= 1'b1;
         else if (w_ovr_clr) r_ovr <= 1'b0;
      end
   end

endmodule
